// File: rtl/four_to_one_rr_mux.sv
// Round-robin merge of four valid/ready channels onto one registered output; 1-cycle latency.
// A stalled output (out_valid && !out_ready) holds the beat and drops every channel ready.
module four_to_one_rr_mux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic             in1_valid,
    input  logic             in2_valid,
    input  logic             in3_valid,
    input  logic             in4_valid,
    output logic             in1_ready,
    output logic             in2_ready,
    output logic             in3_ready,
    output logic             in4_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             s1,
    output logic             s0,
    output logic [15:0]      beat_count
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      beat_count_q, beat_count_d;

    logic [3:0]       vld;
    logic [3:0]       rdy;
    logic [WIDTH-1:0] din [4];
    logic [1:0]       gnt_idx;
    logic             gnt_found;
    logic             load_ok;
    logic             take;

    assign vld     = {in4_valid, in3_valid, in2_valid, in1_valid};
    assign din[0]  = in1;
    assign din[1]  = in2;
    assign din[2]  = in3;
    assign din[3]  = in4;
    assign load_ok = !out_valid_q || out_ready;

    // Scan ptr, ptr+1, ptr+2, ptr+3; the 2-bit sum wraps mod 4 by itself.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (!gnt_found && vld[ptr_q + 2'(i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = ptr_q + 2'(i);
            end
        end
    end

    assign take = gnt_found && load_ok && !rst;
    assign rdy  = take ? (4'b0001 << gnt_idx) : 4'b0000;

    always_comb begin
        out_d        = out_q;
        sel_d        = sel_q;
        ptr_d        = ptr_q;
        out_valid_d  = out_valid_q;
        beat_count_d = beat_count_q + {15'd0, (out_valid_q && out_ready)};
        if (load_ok) begin
            if (take) begin
                out_d       = din[gnt_idx];
                sel_d       = gnt_idx;
                ptr_d       = gnt_idx + 2'd1;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            sel_q        <= 2'd0;
            ptr_q        <= 2'd0;
            out_valid_q  <= 1'b0;
            beat_count_q <= 16'd0;
        end else begin
            out_q        <= out_d;
            sel_q        <= sel_d;
            ptr_q        <= ptr_d;
            out_valid_q  <= out_valid_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign {in4_ready, in3_ready, in2_ready, in1_ready} = rdy;
    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign {s1, s0}   = sel_q;
    assign beat_count = beat_count_q;

endmodule

// File: tb/tb_four_to_one_rr_mux.sv
// Bench for four_to_one_rr_mux: directed vector table, reset/wrap sequences, randomized run vs reference model.
// Inputs change 1ns after posedge; readys sampled at negedge, registered outputs 1ns after posedge.
module tb_four_to_one_rr_mux;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [W-1:0]  in1, in2, in3, in4;
    logic          in1_valid, in2_valid, in3_valid, in4_valid;
    logic          in1_ready, in2_ready, in3_ready, in4_ready;
    logic [W-1:0]  out;
    logic          out_valid, out_ready, s1, s0;
    logic [15:0]   beat_count;

    four_to_one_rr_mux #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .in1_valid(in1_valid), .in2_valid(in2_valid), .in3_valid(in3_valid), .in4_valid(in4_valid),
        .in1_ready(in1_ready), .in2_ready(in2_ready), .in3_ready(in3_ready), .in4_ready(in4_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .s1(s1), .s0(s0), .beat_count(beat_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  vld;
        logic        ordy;
        logic [31:0] dat;
        logic [3:0]  x_rdy;
        logic        x_ov;
        logic [7:0]  x_out;
        logic [1:0]  x_sel;
        logic [15:0] x_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] rdy_bus();
        return {in4_ready, in3_ready, in2_ready, in1_ready};
    endfunction

    task automatic drive(input logic [3:0] v, input logic ordy, input logic [31:0] d);
        {in4_valid, in3_valid, in2_valid, in1_valid} = v;
        out_ready = ordy;
        {in4, in3, in2, in1} = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [7:0] o,
                             input logic [1:0] sel, input logic [15:0] cnt);
        check({tag, "_out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, "_out"}, 32'(out), 32'(o));
        check({tag, "_sel"}, 32'({s1, s0}), 32'(sel));
        check({tag, "_beat_count"}, 32'(beat_count), 32'(cnt));
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic ordy, input logic [31:0] d,
                                input logic [3:0] xr, input logic xov, input logic [7:0] xo,
                                input logic [1:0] xs, input logic [15:0] xc);
        vec_t r;
        r.vld = v; r.ordy = ordy; r.dat = d; r.x_rdy = xr;
        r.x_ov = xov; r.x_out = xo; r.x_sel = xs; r.x_cnt = xc;
        return r;
    endfunction

    localparam logic [31:0] DN = 32'h44332211;
    localparam logic [31:0] DA = 32'h44A52211;

    vec_t tbl [17];

    // Reference model state for the randomized run
    logic [3:0]  rv;
    logic [7:0]  rd [4];
    int          seq [4];
    int          waitc [4];
    int          m_ptr;
    logic        m_ov;
    logic [15:0] m_cnt;
    logic [9:0]  q [$];

    initial begin
        tbl[0]  = mk(4'b0100, 1'b1, DA, 4'b0100, 1'b1, 8'hA5, 2'd2, 16'd0);
        tbl[1]  = mk(4'b0000, 1'b1, DA, 4'b0000, 1'b0, 8'hA5, 2'd2, 16'd1);
        tbl[2]  = mk(4'b1000, 1'b1, DN, 4'b1000, 1'b1, 8'h44, 2'd3, 16'd1);
        tbl[3]  = mk(4'b1111, 1'b1, DN, 4'b0001, 1'b1, 8'h11, 2'd0, 16'd2);
        tbl[4]  = mk(4'b1111, 1'b1, DN, 4'b0010, 1'b1, 8'h22, 2'd1, 16'd3);
        tbl[5]  = mk(4'b1111, 1'b1, DN, 4'b0100, 1'b1, 8'h33, 2'd2, 16'd4);
        tbl[6]  = mk(4'b1111, 1'b1, DN, 4'b1000, 1'b1, 8'h44, 2'd3, 16'd5);
        tbl[7]  = mk(4'b1111, 1'b1, DN, 4'b0001, 1'b1, 8'h11, 2'd0, 16'd6);
        tbl[8]  = mk(4'b0010, 1'b1, DN, 4'b0010, 1'b1, 8'h22, 2'd1, 16'd7);
        tbl[9]  = mk(4'b1001, 1'b0, DN, 4'b0000, 1'b1, 8'h22, 2'd1, 16'd7);
        tbl[10] = mk(4'b1001, 1'b0, DN, 4'b0000, 1'b1, 8'h22, 2'd1, 16'd7);
        tbl[11] = mk(4'b1001, 1'b0, DN, 4'b0000, 1'b1, 8'h22, 2'd1, 16'd7);
        tbl[12] = mk(4'b1001, 1'b1, DN, 4'b1000, 1'b1, 8'h44, 2'd3, 16'd8);
        tbl[13] = mk(4'b0000, 1'b1, DN, 4'b0000, 1'b0, 8'h44, 2'd3, 16'd9);
        tbl[14] = mk(4'b0000, 1'b1, DN, 4'b0000, 1'b0, 8'h44, 2'd3, 16'd9);
        tbl[15] = mk(4'b0001, 1'b0, DN, 4'b0001, 1'b1, 8'h11, 2'd0, 16'd9);
        tbl[16] = mk(4'b0000, 1'b0, DN, 4'b0000, 1'b1, 8'h11, 2'd0, 16'd9);

        // Reset with every channel requesting: no ready may leak out
        rst = 1'b1;
        drive(4'b1111, 1'b1, DN);
        @(negedge clk);
        check("reset_ready", 32'(rdy_bus()), 32'h0);
        tick();
        check_out("reset", 1'b0, 8'h00, 2'd0, 16'd0);
        rst = 1'b0;
        drive(4'b0000, 1'b1, DN);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].vld, tbl[i].ordy, tbl[i].dat);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), 32'(rdy_bus()), 32'(tbl[i].x_rdy));
            tick();
            check_out($sformatf("vec%0d", i), tbl[i].x_ov, tbl[i].x_out, tbl[i].x_sel, tbl[i].x_cnt);
        end

        // Reset while a beat is stalled on the output
        rst = 1'b1;
        drive(4'b0011, 1'b0, DN);
        @(negedge clk);
        check("rst_stall_ready", 32'(rdy_bus()), 32'h0);
        tick();
        check_out("rst_stall", 1'b0, 8'h00, 2'd0, 16'd0);
        rst = 1'b0;
        drive(4'b0011, 1'b1, DN);
        @(negedge clk);
        check("post_rst_ready0", 32'(rdy_bus()), 32'h1);
        tick();
        check_out("post_rst0", 1'b1, 8'h11, 2'd0, 16'd0);
        @(negedge clk);
        check("post_rst_ready1", 32'(rdy_bus()), 32'h2);
        tick();
        check_out("post_rst1", 1'b1, 8'h22, 2'd1, 16'd1);

        // beat_count wrap: one handshake per cycle from a fresh reset
        rst = 1'b1;
        drive(4'b0000, 1'b0, DN);
        tick();
        rst = 1'b0;
        drive(4'b0001, 1'b1, DN);
        for (int i = 0; i < 65536; i++) tick();
        check("wrap_preload", 32'(beat_count), 32'hFFFF);
        tick();
        check("wrap_zero", 32'(beat_count), 32'h0);

        // Randomized run against the reference model
        rst = 1'b1;
        drive(4'b0000, 1'b0, DN);
        tick();
        rst = 1'b0;
        rv = 4'b0000;
        m_ptr = 0;
        m_ov = 1'b0;
        m_cnt = 16'd0;
        for (int k = 0; k < 4; k++) begin
            seq[k] = 0;
            waitc[k] = 0;
            rd[k] = 8'h00;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic ordy, load_ok;
            int g;
            for (int k = 0; k < 4; k++) begin
                if (!rv[k] && $urandom_range(0, 2) != 0) begin
                    rv[k] = 1'b1;
                    rd[k] = 8'(k * 64 + seq[k] % 64);
                    waitc[k] = 0;
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            drive(rv, ordy, {rd[3], rd[2], rd[1], rd[0]});
            @(negedge clk);
            load_ok = !m_ov || ordy;
            g = -1;
            if (load_ok) begin
                for (int i = 0; i < 4; i++) begin
                    if (g < 0 && rv[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
                end
            end
            check("rnd_ready", 32'(rdy_bus()), (g >= 0) ? (32'h1 << g) : 32'h0);
            check("rnd_out_valid", 32'(out_valid), 32'(m_ov));
            check("rnd_beat_count", 32'(beat_count), 32'(m_cnt));
            if (m_ov) begin
                if (q.size() == 0) begin
                    check("rnd_queue_nonempty", 32'(q.size()), 32'h1);
                end else begin
                    check("rnd_out", 32'(out), 32'(q[0][7:0]));
                    check("rnd_sel", 32'({s1, s0}), 32'(q[0][9:8]));
                end
            end
            if (m_ov && ordy) begin
                if (q.size() != 0) void'(q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (g >= 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (rv[k]) begin
                        waitc[k]++;
                        check($sformatf("rnd_starve_ch%0d", k + 1), 32'(waitc[k] <= 4), 32'h1);
                    end
                end
                q.push_back({2'(g), rd[g]});
                m_ptr = (g + 1) % 4;
                m_ov = 1'b1;
            end else if (load_ok) begin
                m_ov = 1'b0;
            end
            tick();
            if (g >= 0) begin
                rv[g] = 1'b0;
                seq[g]++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
